diffeq_job_feeder: RTL

- Upstream job stage for the Euler differential-equation solver.
- Accepts solver jobs (x0, y0, u0, limit a, step dx) over a valid/ready stream and buffers them in a small FIFO.
- Launches one job at a time by presenting stable operands plus a one-cycle start pulse, then waits for the solver's done pulse or a timeout.
- Filters degenerate jobs (dx == 0) and keeps status counters.

---
 rtl/diffeq_job_feeder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/diffeq_job_feeder.sv
// Purpose: queues Euler-solver jobs and launches them one at a time onto the solver.
// Latency: push at edge T into an empty, idle feeder gives sol_start in cycle T+2.
// Backpressure: in_ready drops when the FIFO holds DEPTH jobs; a pop the same cycle does not reopen it.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   in_valid/in_ready, in_*         job stream (x0, y0, u0, limit a, step dx)
//   sol_*, sol_start, sol_done      operands, launch pulse, completion pulse to/from the solver
//   busy, count, job_id             activity, FIFO occupancy, id of the job on sol_*
//   jobs_done, reject_cnt           completed jobs (wraps), dx==0 rejections (saturates)
//   timeout_err                     sticky: a job was abandoned after TIMEOUT run cycles

// Small generic FIFO: registered occupancy, combinational head read.
// Latency: a write is visible at the head one cycle later.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module diffeq_job_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module diffeq_job_feeder #(
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_y,
    input  logic [DW-1:0] in_u,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_dx,
    output logic [DW-1:0] sol_x,
    output logic [DW-1:0] sol_y,
    output logic [DW-1:0] sol_u,
    output logic [DW-1:0] sol_a,
    output logic [DW-1:0] sol_dx,
    output logic          sol_start,
    input  logic          sol_done,
    output logic          busy,
    output logic [AW:0]   count,
    output logic [7:0]    job_id,
    output logic [15:0]   jobs_done,
    output logic [7:0]    reject_cnt,
    output logic          timeout_err
);
    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] u;
        logic [DW-1:0] a;
        logic [DW-1:0] dx;
    } job_t;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

    localparam int              TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int              TLAST_I = TIMEOUT - 1;
    localparam logic [TW-1:0]   TLAST   = TLAST_I[TW-1:0];
    localparam logic [AW:0]     DEPTH_C = DEPTH[AW:0];

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          accept;
    logic          push;
    logic          pop;
    logic          run_done;
    logic          run_timeout;
    job_t          wr_job;
    job_t          head_job;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign in_ready = (count < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_dx != '0);
    assign wr_job   = '{x: in_x, y: in_y, u: in_u, a: in_a, dx: in_dx};

    diffeq_job_fifo #(
        .W     ($bits(job_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (wr_job),
        .pop      (pop),
        .pop_dat  (head_job),
        .count    (count)
    );

    // Done takes priority over a timeout landing in the same cycle.
    assign run_done    = (state == S_RUN) && sol_done;
    assign run_timeout = (state == S_RUN) && !sol_done && (timer == TLAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (count != '0) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (run_done || run_timeout) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pop       = 1'b0;
        sol_start = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE:   pop = (count != '0);
            S_LAUNCH: begin
                sol_start = 1'b1;
                busy      = 1'b1;
            end
            S_RUN:    busy = 1'b1;
            default:  ;
        endcase
    end

    // Operand registers, run timer and status counters
    always_ff @(posedge clk) begin
        if (reset) begin
            sol_x       <= '0;
            sol_y       <= '0;
            sol_u       <= '0;
            sol_a       <= '0;
            sol_dx      <= '0;
            timer       <= '0;
            job_id      <= '0;
            jobs_done   <= '0;
            reject_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Operands change only on a pop, so they stay stable through RUN and IDLE.
            if (pop) begin
                sol_x  <= head_job.x;
                sol_y  <= head_job.y;
                sol_u  <= head_job.u;
                sol_a  <= head_job.a;
                sol_dx <= head_job.dx;
            end
            if (state == S_LAUNCH)   timer <= '0;
            else if (state == S_RUN) timer <= timer + 1'b1;
            if (run_done) begin
                jobs_done <= jobs_done + 1'b1;
                job_id    <= job_id + 1'b1;
            end
            if (run_timeout) begin
                timeout_err <= 1'b1;
                job_id      <= job_id + 1'b1;
            end
            if (accept && (in_dx == '0) && (reject_cnt != 8'hFF))
                reject_cnt <= reject_cnt + 1'b1;
        end
    end
endmodule
